// File: rtl/stream_mux_ctrl.sv
// Frame-aligned select sequencer for the camera/SA stream mux.
// It switches the mux source only on frame boundaries, or when the watchdog forces a switch after a stall.
module stream_mux_ctrl #(
    parameter int LINES_PER_FRAME = 480,
    parameter int TIMEOUT         = 1024,
    parameter int LW              = $clog2(LINES_PER_FRAME)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_req,
    input  logic          tvalid_camera,
    input  logic          tlast_camera,
    input  logic          tvalid_SA,
    input  logic          tlast_SA,
    input  logic          tready_out,
    output logic          en,
    output logic          pending,
    output logic          switch_pulse,
    output logic          timeout_err,
    output logic [LW-1:0] line_cnt,
    output logic [15:0]   frame_cnt
);

    localparam int IW = $clog2(TIMEOUT);

    // Bit 1 is the selected source and bit 0 is the pending flag, so the outputs are plain flop bits.
    typedef enum logic [1:0] {
        CAM_RUN  = 2'b00,
        CAM_PEND = 2'b01,
        SA_RUN   = 2'b10,
        SA_PEND  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   line_cnt_q, line_cnt_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            mid_frame_q, mid_frame_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            switch_pulse_q, switch_pulse_d;
    logic            timeout_err_q, timeout_err_d;

    logic sel_sa, sel_valid, sel_last;
    logic acc, line_end, frame_end;
    logic differs, norm_sw, force_sw;

    always_comb begin
        sel_sa    = state_q[1];
        sel_valid = sel_sa ? tvalid_SA : tvalid_camera;
        sel_last  = sel_sa ? tlast_SA  : tlast_camera;
        acc       = sel_valid & tready_out;
        line_end  = acc & sel_last;
        frame_end = line_end & (line_cnt_q == LW'(LINES_PER_FRAME - 1));
        differs   = (mode_req != sel_sa);
        norm_sw   = frame_end | (~mid_frame_q & ~acc);
        force_sw  = ~acc & (idle_cnt_q == IW'(TIMEOUT - 1));

        state_d        = state_q;
        line_cnt_d     = line_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        mid_frame_d    = mid_frame_q;
        idle_cnt_d     = '0;
        switch_pulse_d = 1'b0;
        timeout_err_d  = 1'b0;

        if (acc) begin
            mid_frame_d = 1'b1;
        end
        if (frame_end) begin
            line_cnt_d  = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            mid_frame_d = 1'b0;
        end else if (line_end) begin
            line_cnt_d = line_cnt_q + LW'(1);
        end

        // A cancel takes priority over any switch condition in the same cycle.
        case (state_q)
            CAM_RUN:  if (differs) state_d = CAM_PEND;
            SA_RUN:   if (differs) state_d = SA_PEND;
            CAM_PEND, SA_PEND: begin
                if (!differs) begin
                    state_d = sel_sa ? SA_RUN : CAM_RUN;
                end else if (norm_sw || force_sw) begin
                    state_d        = sel_sa ? CAM_RUN : SA_RUN;
                    switch_pulse_d = 1'b1;
                    timeout_err_d  = force_sw & ~norm_sw;
                    line_cnt_d     = '0;
                    mid_frame_d    = 1'b0;
                end else if (!acc) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            default: state_d = CAM_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= CAM_RUN;
            line_cnt_q     <= '0;
            frame_cnt_q    <= '0;
            mid_frame_q    <= 1'b0;
            idle_cnt_q     <= '0;
            switch_pulse_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            line_cnt_q     <= line_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            mid_frame_q    <= mid_frame_d;
            idle_cnt_q     <= idle_cnt_d;
            switch_pulse_q <= switch_pulse_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign en           = state_q[1];
    assign pending      = state_q[0];
    assign switch_pulse = switch_pulse_q;
    assign timeout_err  = timeout_err_q;
    assign line_cnt     = line_cnt_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_stream_mux_ctrl.sv
// Directed testbench for stream_mux_ctrl with a queued expected-output scoreboard.
module tb_stream_mux_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_req, tvalid_camera, tlast_camera, tvalid_SA, tlast_SA, tready_out;
    logic        en, pending, switch_pulse, timeout_err;
    logic [1:0]  line_cnt;
    logic [15:0] frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        en;
        logic        pend;
        logic        sp;
        logic        te;
        logic [1:0]  line;
        logic [15:0] frame;
    } exp_t;

    exp_t  sb[$];
    string tq[$];

    stream_mux_ctrl #(.LINES_PER_FRAME(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req),
        .tvalid_camera(tvalid_camera), .tlast_camera(tlast_camera),
        .tvalid_SA(tvalid_SA), .tlast_SA(tlast_SA), .tready_out(tready_out),
        .en(en), .pending(pending), .switch_pulse(switch_pulse),
        .timeout_err(timeout_err), .line_cnt(line_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic e, input logic p, input logic s, input logic t,
                                input int l, input int f);
        exp_t x;
        x.en = e; x.pend = p; x.sp = s; x.te = t;
        x.line = 2'(l); x.frame = 16'(f);
        return x;
    endfunction

    task automatic cmp(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] ex);
        n_assert++;
        assert (obs === ex) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, ex);
        end
    endtask

    task automatic check_now();
        exp_t  x;
        string tag;
        x   = sb.pop_front();
        tag = tq.pop_front();
        cmp(tag, "en", 16'(en), 16'(x.en));
        cmp(tag, "pending", 16'(pending), 16'(x.pend));
        cmp(tag, "switch_pulse", 16'(switch_pulse), 16'(x.sp));
        cmp(tag, "timeout_err", 16'(timeout_err), 16'(x.te));
        cmp(tag, "line_cnt", 16'(line_cnt), 16'(x.line));
        cmp(tag, "frame_cnt", frame_cnt, x.frame);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
    task automatic step(input string tag, input logic m, input logic vc, input logic lc,
                        input logic vs, input logic ls, input logic rdy, input exp_t x);
        mode_req = m; tvalid_camera = vc; tlast_camera = lc;
        tvalid_SA = vs; tlast_SA = ls; tready_out = rdy;
        sb.push_back(x);
        tq.push_back(tag);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        mode_req = 0; tvalid_camera = 0; tlast_camera = 0;
        tvalid_SA = 0; tlast_SA = 0; tready_out = 1;
        rst = 1'b1;
        #3;
        sb.push_back(mk(0, 0, 0, 0, 0, 0)); tq.push_back("reset");
        check_now();
        @(posedge clk); #1;
        rst = 1'b0;

        // Beats on the unselected stream and beats without ready must not count.
        step("ignore_sa", 0, 0, 0, 1, 1, 1, mk(0, 0, 0, 0, 0, 0));
        step("no_ready", 0, 1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 8; k++)
            step($sformatf("cam_line%0d", k), 0, 1, 1, 1, 1, 1, mk(0, 0, 0, 0, (k + 1) % 4, (k + 1) / 4));

        // Idle at a frame boundary: select moves two cycles after the request.
        step("idle_req", 1, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 0, 2));
        step("idle_sw", 1, 0, 0, 0, 0, 1, mk(1, 0, 1, 0, 0, 2));
        step("idle_after", 1, 0, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 2));
        step("back_req", 0, 0, 0, 0, 0, 1, mk(1, 1, 0, 0, 0, 2));
        step("back_sw", 0, 0, 0, 0, 0, 1, mk(0, 0, 1, 0, 0, 2));

        // Request during camera line 1: switch only after the frame-end beat.
        step("b_line0", 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 1, 2));
        step("b_req", 1, 1, 0, 0, 0, 1, mk(0, 1, 0, 0, 1, 2));
        step("b_line1", 1, 1, 1, 0, 0, 1, mk(0, 1, 0, 0, 2, 2));
        step("b_stall", 1, 0, 0, 0, 0, 1, mk(0, 1, 0, 0, 2, 2));
        step("b_line2", 1, 1, 1, 0, 0, 1, mk(0, 1, 0, 0, 3, 2));
        step("b_fend", 1, 1, 1, 0, 0, 1, mk(1, 0, 1, 0, 0, 3));
        step("b_after", 1, 0, 0, 0, 0, 1, mk(1, 0, 0, 0, 0, 3));

        // Stall the SA source mid-frame while a switch back is pending.
        step("d_sa0", 1, 0, 0, 1, 1, 1, mk(1, 0, 0, 0, 1, 3));
        step("d_sa1", 1, 0, 0, 1, 1, 1, mk(1, 0, 0, 0, 2, 3));
        step("d_sa2mid", 1, 0, 0, 1, 0, 1, mk(1, 0, 0, 0, 2, 3));
        step("d_req", 0, 0, 0, 0, 0, 1, mk(1, 1, 0, 0, 2, 3));
        for (int i = 0; i < 15; i++)
            step($sformatf("d_wait%0d", i), 0, 0, 0, 0, 0, 1, mk(1, 1, 0, 0, 2, 3));
        step("d_timeout", 0, 0, 0, 0, 0, 1, mk(0, 0, 1, 1, 0, 3));
        step("d_after", 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 3));

        // Request then cancel before the frame ends.
        step("e_line0", 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 1, 3));
        step("e_req", 1, 1, 0, 0, 0, 1, mk(0, 1, 0, 0, 1, 3));
        step("e_line1", 1, 1, 1, 0, 0, 1, mk(0, 1, 0, 0, 2, 3));
        step("e_cancel", 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 2, 3));
        step("e_line2", 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 3, 3));
        step("e_line3", 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 0, 4));

        // Frame end and request on the same cycle: pend first, switch next cycle.
        for (int k = 0; k < 3; k++)
            step($sformatf("s_line%0d", k), 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, k + 1, 4));
        step("s_fend_req", 1, 1, 1, 0, 0, 1, mk(0, 1, 0, 0, 0, 5));
        step("s_sw", 1, 0, 0, 0, 0, 1, mk(1, 0, 1, 0, 0, 5));

        // Asynchronous reset while pending mid-frame on SA.
        step("f_sa0", 1, 0, 0, 1, 1, 1, mk(1, 0, 0, 0, 1, 5));
        step("f_sa1", 1, 0, 0, 1, 1, 1, mk(1, 0, 0, 0, 2, 5));
        step("f_req", 0, 0, 0, 1, 0, 1, mk(1, 1, 0, 0, 2, 5));
        #3;
        rst = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0)); tq.push_back("f_rst");
        check_now();
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        step("f_restart", 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 1, 0));
        step("f_restart2", 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 2, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
